// File: rtl/md_vel_pkg.sv
// Shared types and constants for the velocity cell streamer.
//   DataWidth / AddrWidth : RAM word and address widths
//   vel_t                 : one velocity word {vz, vy, vx}
//   stream_word_t         : output FIFO entry {vel, id}
//   state_e               : controller states
package md_vel_pkg;

  localparam int unsigned DataWidth = 96;
  localparam int unsigned AddrWidth = 8;

  typedef struct packed {
    logic [31:0] vz;
    logic [31:0] vy;
    logic [31:0] vx;
  } vel_t;

  typedef struct packed {
    vel_t                 vel;
    logic [AddrWidth-1:0] id;
  } stream_word_t;

  typedef enum logic [2:0] {
    StIdle,
    StCntRd,
    StCntWait,
    StStream,
    StFinish
  } state_e;

endpackage

// File: rtl/velocity_cell_streamer_if.sv
// Stream-out and write-back handshakes between the streamer and the motion-update unit.
//   out_vel/out_id/out_valid/out_ready : velocity stream towards motion update
//   wb_vel/wb_id/wb_valid/wb_ready     : updated velocities coming back
// master = streamer side, slave = motion-update side.
interface velocity_cell_streamer_if;
  import md_vel_pkg::*;

  logic [DataWidth-1:0] out_vel;
  logic [AddrWidth-1:0] out_id;
  logic                 out_valid;
  logic                 out_ready;
  logic [DataWidth-1:0] wb_vel;
  logic [AddrWidth-1:0] wb_id;
  logic                 wb_valid;
  logic                 wb_ready;

  modport master (
    output out_vel, out_id, out_valid,
    input  out_ready,
    input  wb_vel, wb_id, wb_valid,
    output wb_ready
  );

  modport slave (
    input  out_vel, out_id, out_valid,
    output out_ready,
    output wb_vel, wb_id, wb_valid,
    input  wb_ready
  );

endinterface

// File: rtl/vel_skid_fifo.sv
// Two-entry fall-through FIFO for the velocity stream.
//   clock, rst_n            : clock, async active-low reset
//   in_valid_i / in_data_i  : word arriving from the RAM (caller guarantees space)
//   out_valid_o/out_data_o  : head word, out_ready_i pops it
//   occupancy_o             : number of stored entries (bypassed words not counted)
module vel_skid_fifo
  import md_vel_pkg::*;
(
  input  logic         clock,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  stream_word_t in_data_i,
  output logic         out_valid_o,
  output stream_word_t out_data_o,
  input  logic         out_ready_i,
  output logic [1:0]   occupancy_o
);

  stream_word_t store_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         empty, bypass, push, pop;

  always_comb begin
    empty       = (cnt_q == 2'd0);
    // An arriving word goes straight out when nothing is queued ahead of it.
    bypass      = empty & in_valid_i & out_ready_i;
    push        = in_valid_i & ~bypass;
    pop         = ~empty & out_ready_i;
    out_valid_o = ~empty | in_valid_i;
    out_data_o  = '0;
    if (!empty) begin
      out_data_o = store_q[rd_ptr_q];
    end else if (in_valid_i) begin
      out_data_o = in_data_i;
    end
    occupancy_o = cnt_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      store_q[0] <= '0;
      store_q[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      if (push) begin
        store_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/velocity_cell_streamer.sv
// Sole master of one per-cell velocity RAM (word 0 = count N, words 1..N = velocities).
// On start reads N, streams every velocity out and writes returned velocities back.
//   clock, rst_n        : clock, async active-low reset
//   start_i             : one-cycle start pulse (ignored unless idle)
//   busy_o / done_o     : cell in progress / one-cycle completion pulse
//   mem_*               : single-port RAM with 1-cycle read latency
//   cell_if (master)    : stream-out and write-back handshakes
//   wb_err_o            : sticky bad-write-back flag
// Optional: VEL_WB_CHECK_EN enables write-back id checking (suppresses bad writes).
module velocity_cell_streamer
  import md_vel_pkg::*;
#(
  parameter int unsigned ParticleNum = 220
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [AddrWidth-1:0]     mem_address_o,
  output logic [DataWidth-1:0]     mem_data_o,
  output logic                     mem_rden_o,
  output logic                     mem_wren_o,
  input  logic [DataWidth-1:0]     mem_q_i,
  velocity_cell_streamer_if.master cell_if,
  output logic                     wb_err_o
);

  localparam logic [AddrWidth-1:0] MaxCount = AddrWidth'(ParticleNum - 1);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] n_q, n_d, rd_ptr_q, rd_ptr_d, rd_id_q;
  logic [AddrWidth-1:0] out_cnt_q, out_cnt_d, wb_cnt_q, wb_cnt_d, addr_q;
  logic                 inflight_q;
  logic                 wb_fire, wb_bad, rd_en, cnt_rd, out_fire, fifo_valid;
  logic [1:0]           fifo_occ;
  stream_word_t         fifo_in, fifo_out;

  assign wb_fire = cell_if.wb_valid & (state_q == StStream);

`ifdef VEL_WB_CHECK_EN
  logic wb_err_q, wb_err_d;

  always_comb begin
    // out_cnt_q <= N, so "not yet streamed" also covers ids beyond N.
    wb_bad   = (cell_if.wb_id == '0) | (cell_if.wb_id > out_cnt_q);
    wb_err_d = wb_err_q;
    if ((state_q == StIdle) && start_i) begin
      wb_err_d = 1'b0;
    end else if (wb_fire && wb_bad) begin
      wb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wb_err_q <= 1'b0;
    end else begin
      wb_err_q <= wb_err_d;
    end
  end

  assign wb_err_o = wb_err_q;
`else
  assign wb_bad   = 1'b0;
  assign wb_err_o = 1'b0;
`endif

  assign fifo_in.vel = mem_q_i;
  assign fifo_in.id  = rd_id_q;

  vel_skid_fifo u_fifo (
    .clock       (clock),
    .rst_n       (rst_n),
    .in_valid_i  (inflight_q),
    .in_data_i   (fifo_in),
    .out_valid_o (fifo_valid),
    .out_data_o  (fifo_out),
    .out_ready_i (cell_if.out_ready),
    .occupancy_o (fifo_occ)
  );

  always_comb begin
    out_fire = fifo_valid & cell_if.out_ready;
    cnt_rd   = (state_q == StCntRd);
    // Credit: stored words plus the read in flight must leave room for this read.
    rd_en    = (state_q == StStream) & ~wb_fire & (rd_ptr_q <= n_q) &
               (({1'b0, fifo_occ} + {2'b00, inflight_q}) < 3'd2);

    mem_wren_o = wb_fire & ~wb_bad;
    mem_rden_o = rd_en | cnt_rd;
    mem_data_o = mem_wren_o ? cell_if.wb_vel : '0;
    if (mem_wren_o) begin
      mem_address_o = cell_if.wb_id;
    end else if (rd_en) begin
      mem_address_o = rd_ptr_q;
    end else if (cnt_rd) begin
      mem_address_o = '0;
    end else begin
      mem_address_o = addr_q;
    end

    cell_if.out_valid = fifo_valid;
    cell_if.out_vel   = fifo_out.vel;
    cell_if.out_id    = fifo_out.id;
    cell_if.wb_ready  = (state_q == StStream);
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    rd_ptr_d  = rd_ptr_q;
    out_cnt_d = out_cnt_q + {{(AddrWidth-1){1'b0}}, out_fire};
    wb_cnt_d  = wb_cnt_q + {{(AddrWidth-1){1'b0}}, wb_fire};
    busy_o    = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StCntRd;
          out_cnt_d = '0;
          wb_cnt_d  = '0;
        end
      end
      StCntRd: begin
        busy_o  = 1'b1;
        state_d = StCntWait;
      end
      StCntWait: begin
        busy_o   = 1'b1;
        n_d      = (mem_q_i[AddrWidth-1:0] > MaxCount) ? MaxCount : mem_q_i[AddrWidth-1:0];
        rd_ptr_d = AddrWidth'(1);
        state_d  = (n_d == '0) ? StFinish : StStream;
      end
      StStream: begin
        busy_o = 1'b1;
        if (rd_en) begin
          rd_ptr_d = rd_ptr_q + AddrWidth'(1);
        end
        // Use next-state counts so done follows the last event by one cycle.
        if ((out_cnt_d == n_q) && (wb_cnt_d >= n_q)) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      n_q        <= '0;
      rd_ptr_q   <= '0;
      rd_id_q    <= '0;
      inflight_q <= 1'b0;
      out_cnt_q  <= '0;
      wb_cnt_q   <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= rd_en;
      out_cnt_q  <= out_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
      addr_q     <= mem_address_o;
      if (rd_en) begin
        rd_id_q <= rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_velocity_cell_streamer.sv
module tb_velocity_cell_streamer;
  import md_vel_pkg::*;

`ifdef VEL_WB_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  id;
    logic [95:0] vel;
  } exp_t;

  logic                 clock = 1'b0;
  logic                 rst_n, start, busy, done, mem_rden, mem_wren, wb_err;
  logic [AddrWidth-1:0] mem_address;
  logic [DataWidth-1:0] mem_data;
  logic [DataWidth-1:0] mem_q = '0;
  logic [95:0]          ram [256];
  logic [95:0]          model [256];
  logic                 ld_en;
  logic [7:0]           ld_addr;
  logic [95:0]          ld_data;
  exp_t                 exp_q [$];
  int cyc, checks, errors, wren_seen, done_seen, done_cyc, valid_seen, fired, ready_mode;
  int fire_cyc [256];
  bit          prev_stall;
  logic [95:0] prev_vel;
  logic [7:0]  prev_id;

  velocity_cell_streamer_if sif ();

  velocity_cell_streamer dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .start_i       (start),
    .busy_o        (busy),
    .done_o        (done),
    .mem_address_o (mem_address),
    .mem_data_o    (mem_data),
    .mem_rden_o    (mem_rden),
    .mem_wren_o    (mem_wren),
    .mem_q_i       (mem_q),
    .cell_if       (sif),
    .wb_err_o      (wb_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // RAM model: 1-cycle read latency; bench load port has priority.
  always @(posedge clock) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (mem_wren) ram[mem_address] <= mem_data;
    if (mem_rden) mem_q <= ram[mem_address];
  end

  function automatic logic [95:0] vel_of(input int i, input logic [7:0] salt);
    return {salt, 24'(i), salt + 8'd1, 24'(i), salt + 8'd2, 24'(i)};
  endfunction

  task automatic check(input string name, input bit ok, input logic [127:0] act,
                       input logic [127:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic bit outs_zero();
    return !busy && !done && mem_address == '0 && mem_data == '0 && !mem_rden && !mem_wren &&
           !sif.out_valid && sif.out_vel == '0 && sif.out_id == '0 && !sif.wb_ready && !wb_err;
  endfunction

  function automatic logic [127:0] outs_snap();
    return {busy, done, mem_rden, mem_wren, sif.out_valid, sif.wb_ready, wb_err,
            mem_address, sif.out_id, |mem_data, |sif.out_vel};
  endfunction

  // Scoreboard monitor.
  always @(negedge clock) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_rden || mem_wren) check("rd_wr_excl", !(mem_rden && mem_wren), 2'b11, 2'b01);
      if (mem_wren) wren_seen++;
      if (done) begin
        done_seen++;
        done_cyc = cyc;
      end
      if (sif.out_valid) valid_seen++;
      if (prev_stall)
        check("stall_stable", sif.out_valid && sif.out_vel == prev_vel && sif.out_id == prev_id,
              {sif.out_valid, sif.out_id, sif.out_vel}, {1'b1, prev_id, prev_vel});
      if (sif.out_valid && sif.out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1'b0, sif.out_id, 0);
        end else begin
          e = exp_q.pop_front();
          check("stream_word", sif.out_id == e.id && sif.out_vel == e.vel,
                {sif.out_id, sif.out_vel}, {e.id, e.vel});
          fire_cyc[sif.out_id] = cyc;
          fired++;
        end
      end
      prev_stall = sif.out_valid && !sif.out_ready;
      prev_vel   = sif.out_vel;
      prev_id    = sif.out_id;
    end
  end

  // Downstream ready pattern: 0 = always 1, 1 = toggle, 2 = always 0.
  initial begin
    sif.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        1:       sif.out_ready = ~sif.out_ready;
        2:       sif.out_ready = 1'b0;
        default: sif.out_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // All stimulus tasks return just after a rising edge.
  task automatic load_word(input logic [7:0] a, input logic [95:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clock); #1;
    ld_en = 1'b0;
  endtask

  task automatic push_exp(input int n);
    for (int id = 1; id <= n; id++) exp_q.push_back({8'(id), model[id]});
  endtask

  task automatic do_start(output int t);
    start = 1'b1; t = cyc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_q_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check("stream_timeout", exp_q.size() == 0, exp_q.size(), 0);
  endtask

  task automatic wait_done(input int snap, input int budget);
    int n = 0;
    while (done_seen == snap && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check("done_count", done_seen == snap + 1, done_seen, snap + 1);
  endtask

  task automatic send_wb(input logic [7:0] id, input logic [95:0] v, input bit exp_wr,
                         output int acc);
    int n = 0;
    sif.wb_id = id; sif.wb_vel = v; sif.wb_valid = 1'b1;
    forever begin
      @(negedge clock);
      if (sif.wb_ready || n > 200) break;
      n++;
    end
    check("wb_accept", sif.wb_ready, n, 0);
    check("wb_write", mem_wren == exp_wr && !mem_rden &&
          (!exp_wr || (mem_address == id && mem_data == v)),
          {mem_wren, mem_rden, mem_address, mem_data}, {exp_wr, 1'b0, id, v});
    acc = cyc;
    @(posedge clock); #1;
  endtask

  initial begin
    int t, acc, snap_d, snap_w, snap_v, snap_f;
    logic [95:0] v;
    rst_n = 1'b0; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    sif.wb_valid = 1'b0; sif.wb_id = '0; sif.wb_vel = '0; ready_mode = 0;
    for (int i = 0; i < 256; i++) begin
      model[i] = vel_of(i, 8'h10);
      load_word(8'(i), model[i]);
    end
    @(negedge clock);
    check("reset_outputs", outs_zero(), outs_snap(), 0);
    @(posedge clock); #1;
    rst_n = 1'b1;

    // N=3, ready always high: ids on t+4..t+6, done only after 3 write-backs.
    load_word(8'd0, 96'd3);
    push_exp(3);
    snap_d = done_seen;
    do_start(t);
    @(negedge clock);
    check("count_read", mem_rden && mem_address == '0, {mem_rden, mem_address}, 9'h100);
    wait_q_empty(100);
    check("t1_id1_cycle", fire_cyc[1] == t + 4, fire_cyc[1], t + 4);
    check("t1_id2_cycle", fire_cyc[2] == t + 5, fire_cyc[2], t + 5);
    check("t1_id3_cycle", fire_cyc[3] == t + 6, fire_cyc[3], t + 6);
    repeat (3) @(posedge clock);
    #1;
    check("t1_no_early_done", busy && done_seen == snap_d, {busy, 8'(done_seen)}, {1'b1, 8'(snap_d)});
    for (int id = 1; id <= 3; id++) begin
      model[id] = vel_of(id, 8'hC0);
      send_wb(8'(id), model[id], 1'b1, acc);
    end
    sif.wb_valid = 1'b0;
    wait_done(snap_d, 20);
    check("t1_done_cycle", done_cyc == acc + 1, done_cyc, acc + 1);
    check("t1_busy_low", !busy, busy, 0);

    // N=0: no stream, no writes, done at t+3.
    load_word(8'd0, 96'd0);
    snap_d = done_seen; snap_v = valid_seen; snap_w = wren_seen;
    do_start(t);
    wait_done(snap_d, 20);
    check("t2_done_cycle", done_cyc == t + 3, done_cyc, t + 3);
    check("t2_no_valid", valid_seen == snap_v, valid_seen - snap_v, 0);
    check("t2_no_write", wren_seen == snap_w, wren_seen - snap_w, 0);

    // N=5 with toggling ready.
    load_word(8'd0, 96'd5);
    push_exp(5);
    snap_d = done_seen; snap_f = fired;
    ready_mode = 1;
    do_start(t);
    wait_q_empty(200);
    ready_mode = 0;
    check("t3_word_count", fired - snap_f == 5, fired - snap_f, 5);
    for (int id = 1; id <= 5; id++) begin
      model[id] = vel_of(id, 8'hA0);
      send_wb(8'(id), model[id], 1'b1, acc);
    end
    sif.wb_valid = 1'b0;
    wait_done(snap_d, 20);

    // Write-back to id 2 every cycle from the start of streaming: writes win, reads slip.
    load_word(8'd0, 96'd3);
    v = vel_of(2, 8'hE0);
    model[2] = ChkEn ? model[2] : v;
    push_exp(3);
    snap_d = done_seen;
    do_start(t);
    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) send_wb(8'd2, v, !ChkEn, acc);
    sif.wb_valid = 1'b0;
    wait_q_empty(100);
    check("t4_read_slip", fire_cyc[1] == t + 7, fire_cyc[1], t + 7);
    wait_done(snap_d, 20);
    check("t4_done_cycle", done_cyc == fire_cyc[3] + 1, done_cyc, fire_cyc[3] + 1);
    check("t4_wb_err", wb_err == ChkEn, wb_err, ChkEn);

    // Count word 250 clamps to 219.
    load_word(8'd0, 96'd250);
    push_exp(219);
    snap_d = done_seen; snap_f = fired;
    do_start(t);
    wait_q_empty(1000);
    check("t5_clamp_count", fired - snap_f == 219, fired - snap_f, 219);
    for (int id = 1; id <= 219; id++) send_wb(8'(id), model[id], 1'b1, acc);
    sif.wb_valid = 1'b0;
    wait_done(snap_d, 20);
    check("t5_done_cycle", done_cyc == acc + 1, done_cyc, acc + 1);

    // Write-back to id 7 while N=3.
    load_word(8'd0, 96'd3);
    push_exp(3);
    snap_d = done_seen;
    do_start(t);
    wait_q_empty(100);
    v = vel_of(7, 8'h70);
    send_wb(8'd7, v, !ChkEn, acc);
    model[7] = ChkEn ? model[7] : v;
    send_wb(8'd1, model[1], 1'b1, acc);
    send_wb(8'd2, model[2], 1'b1, acc);
    sif.wb_valid = 1'b0;
    wait_done(snap_d, 20);
    check("t6_wb_err_sticky", wb_err == ChkEn, wb_err, ChkEn);

    // Reset mid-stream with downstream stalled.
    load_word(8'd0, 96'd5);
    push_exp(5);
    ready_mode = 2;
    do_start(t);
    check("t7_err_cleared", !wb_err, wb_err, 0);
    repeat (6) @(posedge clock);
    #1;
    check("t7_streaming", busy && sif.out_valid, {busy, sif.out_valid}, 2'b11);
    snap_d = done_seen;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("t7_reset_now", outs_zero(), outs_snap(), 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("t7_reset_next", outs_zero(), outs_snap(), 0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (5) @(posedge clock);
    #1;
    check("t7_no_done", done_seen == snap_d && !busy, {busy, 8'(done_seen)}, {1'b0, 8'(snap_d)});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
